muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Multi-cycle scheduler for the HI/LO arithmetic unit: accepts MULT/MULTU/DIV/DIVU issued from the EX stage, stalls the pipeline while the operation runs, and returns a one-cycle HI/LO write. It contains a registered 32x32 multiplier and an iterative radix-2 restoring divider (32 iterations). It sits beside the ALU in EX. Its `hilo_we/hi_out/lo_out` feed the HI/LO register alongside the decoder's `gprtohi/gprtolo` path.

## Interface
- No parameters. Data width is fixed at 32 bits; the result is 64 bits.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  EX holds a mult/div instruction; held high by the stalled pipeline until `done`.
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with `start`.
- a  in  32  rs operand (dividend / multiplicand); sampled with `start`.
- b  in  32  rt operand (divisor / multiplier); sampled with `start`.
- flush  in  1  exception/flush from CP0 path; kills any in-flight operation.
- stall  out  1  pipeline stall request.
- done  out  1  one-cycle completion pulse.
- hilo_we  out  1  HI/LO write enable; equals `done && !flush`.
- hi_out  out  32  product[63:32] or remainder.
- lo_out  out  32  product[31:0] or quotient.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset: state=IDLE, counter=0, all outputs 0.
- IDLE & start & !flush: latch op, |a|, |b|, and sign info.
  - MULT/MULTU: go to MUL.
  - DIV/DIVU: go to DIV with counter=0.
- IDLE & start & flush: start is ignored; state stays IDLE.
- MUL: register the 64-bit product (signed for MULT, unsigned for MULTU), then go to DONE.
- DIV: one restoring step per cycle on the magnitudes. Counter increments; after counter=31, go to DONE.
- DIV sign correction, signed only:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncation toward zero).
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally. `start` is ignored in DONE (it is the same instruction still held in EX).
- stall = (IDLE & start & !flush) | MUL | DIV. It is combinational and low in DONE so EX advances.
- flush in MUL or DIV: state goes to IDLE next cycle; no `done` and no `hilo_we`.
- flush in DONE: `done`=1 but `hilo_we`=0.
- Arithmetic edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - Division by zero (either latency): hi=a. lo=0xFFFFFFFF, except for signed with a<0, where lo=0x00000001.
- hi_out/lo_out hold their last value outside DONE. They are only meaningful when `done`=1.

## Timing
- Start accepted in cycle T.
- MUL: DONE at T+2 (stall high T, T+1).
- DIV: DIV state T+1..T+32; DONE at T+33 (stall high T..T+32).
- Back-to-back operations: the earliest next accept is DONE+1 (IDLE).
- rst asserted mid-operation: the FSM goes immediately to IDLE and all outputs drop to 0 asynchronously.

## Configuration
- `MULDIV_DIV0_FAST_EN` defined: a DIV/DIVU with b==0 goes IDLE→DONE directly, giving DONE at T+1. Results are as specified above.
- Not defined: division by zero runs the full 32 iterations (DONE at T+33) and gives identical hi/lo values.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 → stall T,T+1; done at T+2; hi=0xFFFFFFFF, lo=0xFFFFFFFA, hilo_we=1.
- DIVU a=100, b=7 → done at T+33; lo=14, hi=2. DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU a=5, b=0 → hi=5, lo=0xFFFFFFFF; done at T+1 with the macro, T+33 without.
- DIV started and flush pulsed at T+10 → IDLE at T+11; no done or hilo_we; a new MULTU issued at T+12 completes at T+14.
- start held high through DONE → exactly one done pulse, no re-issue. Flush during DONE → done=1, hilo_we=0.
- rst asserted at T+5 of a DIV → stall, done and hilo_we go to 0 immediately; FSM in IDLE after rst is released.

Source files
------------

// File: rtl/muldiv_sched.sv
// HI/LO multi-cycle scheduler: registered 32x32 multiplier plus a 32-step radix-2 restoring divider.
// Optional MULDIV_DIV0_FAST_EN: a divide by zero skips the iterations and completes one cycle after accept.
module muldiv_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        flush,
   output logic        stall,
   output logic        done,
   output logic        hilo_we,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q;
   logic [31:0] a_mag, b_mag, quo_q, rem_q;
   logic        q_neg_q, r_neg_q;

   logic        accept, is_signed, is_div, div0_fast;
   logic [31:0] a_abs, b_abs, rem_nx, quo_nx, rem_fix, quo_fix;
   logic [32:0] trial;
   logic [63:0] prod_mag, prod;

   assign accept    = (state_q == IDLE) && start && !flush;
   assign is_signed = !op[0];
   assign is_div    = op[1];
   assign a_abs     = (is_signed && a[31]) ? -a : a;
   assign b_abs     = (is_signed && b[31]) ? -b : b;

`ifdef MULDIV_DIV0_FAST_EN
   assign div0_fast = is_div && (b == 32'd0);
`else
   assign div0_fast = 1'b0;
`endif

   // Work on magnitudes; q_neg_q doubles as the product sign for MULT.
   assign prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
   assign prod     = q_neg_q ? -prod_mag : prod_mag;

   // Restoring step: trial[32] is the borrow, i.e. partial remainder < divisor.
   assign trial = {rem_q, quo_q[31]} - {1'b0, b_mag};
   always_comb begin
      rem_nx = {rem_q[30:0], quo_q[31]};
      quo_nx = {quo_q[30:0], 1'b0};
      if (!trial[32]) begin
         rem_nx = trial[31:0];
         quo_nx = {quo_q[30:0], 1'b1};
      end
   end
   assign quo_fix = q_neg_q ? -quo_nx : quo_nx;
   assign rem_fix = r_neg_q ? -rem_nx : rem_nx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = is_div ? (div0_fast ? DONE : DIV) : MUL;
         MUL:  state_d = flush ? IDLE : DONE;
         DIV:  if (flush) state_d = IDLE;
               else if (cnt_q == 5'd31) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // stall is gated by rst so it drops asynchronously even while start is still held.
   assign stall   = !rst && (accept || (state_q == MUL) || (state_q == DIV));
   assign done    = (state_q == DONE);
   assign hilo_we = done && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         hi_out  <= '0;
         lo_out  <= '0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               a_mag   <= a_abs;
               b_mag   <= b_abs;
               quo_q   <= a_abs;
               rem_q   <= '0;
               cnt_q   <= '0;
               q_neg_q <= is_signed && (a[31] ^ b[31]);
               r_neg_q <= is_signed && a[31];
               if (div0_fast) begin
                  hi_out <= a;
                  lo_out <= (is_signed && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
               end
            end
            MUL: if (!flush) {hi_out, lo_out} <= prod;
            DIV: if (!flush) begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  hi_out <= rem_fix;
                  lo_out <= quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: expected {hi,lo} and latency queued at issue, popped on done.
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        rst, start, flush;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        stall, done, hilo_we;
   logic [31:0] hi_out, lo_out;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_fail = 0;

`ifdef MULDIV_DIV0_FAST_EN
   localparam int DIV0_LAT = 1;
`else
   localparam int DIV0_LAT = 33;
`endif

   muldiv_sched dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .stall(stall), .done(done), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] px, py;
      logic signed [31:0] sx, sy, q, r;
      case (o)
         2'd0: begin
            px = {{32{x[31]}}, x};
            py = {{32{y[31]}}, y};
            return px * py;
         end
         2'd1: return {32'd0, x} * {32'd0, y};
         2'd2: begin
            if (y == 0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sx = x; sy = y;
            q = sx / sy;
            r = sx % sy;
            return {r, q};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e.res = model(o, x, y);
      e.lat = o[1] ? ((y == 0) ? DIV0_LAT : 33) : 2;
      sb_q.push_back(e);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
   endtask

   // Waits (bounded) for done, holds start through DONE, optionally flushes during DONE.
   task automatic wait_done(input string tag, input bit fl);
      int   k;
      bit   stall_ok;
      exp_t e;
      k = 0;
      #1 stall_ok = stall;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (done) break;
         if (!stall) stall_ok = 1'b0;
      end
      e = sb_q.pop_front();
      check({tag, "_lat"}, k, e.lat);
      check({tag, "_stall_busy"}, stall_ok, 1);
      check({tag, "_stall_done"}, stall, 0);
      check({tag, "_hilo"}, {hi_out, lo_out}, e.res);
      if (fl) begin
         flush = 1'b1;
         #1 check({tag, "_flush_we"}, {done, hilo_we}, 2'b10);
      end else begin
         check({tag, "_we"}, hilo_we, 1);
      end
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      check({tag, "_one_pulse"}, {done, hilo_we, stall}, 3'b000);
      check({tag, "_hold"}, {hi_out, lo_out}, e.res);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      #12;
      check("reset_ctl", {stall, done, hilo_we}, 3'b000);
      check("reset_hilo", {hi_out, lo_out}, 64'd0);
      @(negedge clk) rst = 1'b0;

      issue(2'd0, 32'hFFFF_FFFE, 32'd3);          wait_done("mult_neg", 0);
      issue(2'd3, 32'd100, 32'd7);                wait_done("divu", 0);
      issue(2'd2, 32'hFFFF_FFF9, 32'd2);          wait_done("div_neg", 0);
      issue(2'd2, 32'h0000_0007, 32'hFFFF_FFFE);  wait_done("div_negb", 0);
      issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done("div_ovf", 0);
      issue(2'd3, 32'd5, 32'd0);                  wait_done("divu_z", 0);
      issue(2'd2, 32'hFFFF_FFF7, 32'd0);          wait_done("div_z_neg", 0);
      for (int i = 0; i < 4; i++) begin
         logic [31:0] x, y;
         x = $urandom;
         y = $urandom;
         if (i >= 2) y = y >> 20;
         if (y == 0) y = 32'd1;
         issue(2'(i), x, y);
         wait_done("rand", 0);
      end

      // flush at T+10 of a DIV: no completion, then a MULTU completes normally
      @(negedge clk);
      op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done || hilo_we) seen = 1'b1;
      end
      flush = 1'b1; start = 1'b0;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      check("flush_div_idle", {stall, done, hilo_we}, 3'b000);
      check("flush_div_nodone", seen, 0);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done("multu_after_flush", 0);

      issue(2'd0, 32'd5, 32'hFFFF_FFFA);          wait_done("flush_in_done", 1);

      // reset in the middle of a DIV
      @(negedge clk);
      op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_ctl", {stall, done, hilo_we}, 3'b000);
      check("rst_mid_hilo", {hi_out, lo_out}, 64'd0);
      start = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("rst_release_idle", {stall, done, hilo_we}, 3'b000);
      issue(2'd0, 32'd12345, 32'd678);            wait_done("post_rst", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
